// File: rtl/add_serial_pkg.sv
// Shared types and helpers for the serial (digit-at-a-time) adder.
package add_serial_pkg;

    // Handshake/sequencing states of the serial adder.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a step counter that can hold values 0..width/digit.
    function automatic int step_w(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/add_serial_32bit_digit.sv
// Combinational DIGIT-bit ripple-carry adder made of 1-bit full adders.
// Also exposes the carry into its top bit so the caller can form the
// two's-complement overflow flag when this digit holds the word MSB.
module add_digit
    import add_serial_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             ctop
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    // One full adder per bit, carries rippling upward.
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DIGIT];
    assign ctop = c[DIGIT-1];

endmodule

// File: rtl/add_serial_32bit.sv
// Multi-cycle ripple-carry adder: adds DIGIT bits per clock over
// WIDTH/DIGIT cycles, with valid/ready handshakes on both sides and
// registered sum, carry-out and signed-overflow outputs.
module add_serial_32bit
    import add_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ov
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int SW    = step_w(WIDTH, DIGIT);
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    state_t state, state_nx;

    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [SW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             dco, dctop;
    logic             last_step;
    logic [WIDTH-1:0] sum_nx;

    assign last_step = (cnt == LAST);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    add_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (opa[DIGIT-1:0]),
        .b    (opb[DIGIT-1:0]),
        .cin  (carry),
        .s    (dsum),
        .cout (dco),
        .ctop (dctop)
    );

    // The partial result only needs to hold the digits already produced;
    // on the last step the fresh digit tops it off to a full word.
    if (DIGIT == WIDTH) begin : g_single
        assign sum_nx = dsum;
    end else begin : g_multi
        logic [WIDTH-DIGIT-1:0] res;

        assign sum_nx = {dsum, res};

        // Shift each new digit in from the MSB side while busy.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res <= '0;
            end else if (state == ST_BUSY) begin
                res <= sum_nx[WIDTH-1:DIGIT];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: accept in IDLE, run STEPS cycles, hold until taken.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (in_valid)  state_nx = ST_BUSY;
            ST_BUSY: if (last_step) state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand shifting, running carry, step count and output flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        opa   <= op1;
                        opb   <= op2;
                        carry <= ci;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    carry <= dco;
                    cnt   <= cnt + SW'(1);
                    if (last_step) begin
                        sum <= sum_nx;
                        co  <= dco;
                        ov  <= dctop ^ dco;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
